dual_power_trigger: RTL and testbench
=====================================

DUAL_POWER_TRIGGER -- requirements
Module: dual_power_trigger

Interface
REQ-001 Parameter IQ_DATA_WIDTH, default 16, is the signed width of each I and Q component.
REQ-002 Parameter WINDOW_LOG2, default 4, is the log2 of the moving-average window length W.
REQ-003 Port clock, input, 1, is the single clock.
REQ-004 Port reset, input, 1, is the reset: asynchronous, active-low.
REQ-005 Port enable, input, 1, gates processing; when low, all state holds and strobes are ignored.
REQ-006 Ports data_ant1_in / data_ant2_in, input, 2*IQ_DATA_WIDTH each, carry {I,Q} for each antenna, I in the upper half.
REQ-007 Port data_in_strobe, input, 1, marks one valid sample on both antennas; back-to-back strobes are allowed.
REQ-008 Port power_thres, input, 17, is the unsigned average-magnitude threshold.
REQ-009 Ports min_above / min_below, input, 8 each, give the consecutive-sample counts to assert / release; a value of 0 is treated as 1.
REQ-010 Port power_skip, input, 16, is the number of strobed samples discarded after reset.
REQ-011 Ports power_trigger_1 / power_trigger_2, output, 1 each, are the per-antenna triggers consumed by the antenna switch.
REQ-012 Ports avg_mag_1 / avg_mag_2, output, 17 each, are the unsigned windowed average magnitudes.
REQ-013 Port stronger_ant, output, 1, is 1 when avg_mag_2 > avg_mag_1, else 0.

Function
REQ-014 Per-sample magnitude SHALL be |I|+|Q|, 17 bits unsigned; |-32768| = 32768 SHALL be exact.
REQ-015 Each antenna SHALL keep a W-entry ring buffer and a running sum of width 17+WINDOW_LOG2: sum += new - oldest. The sum SHALL never overflow or underflow.
REQ-016 avg_mag_x SHALL equal sum >> WINDOW_LOG2. Before W samples have arrived, empty buffer entries SHALL count as 0.
REQ-017 Pipeline: magnitude is registered on the strobe cycle N, sum and avg are valid at N+2, and FSM and trigger update at N+3. Throughput SHALL be one sample per clock.
REQ-018 Above-threshold condition: avg_mag_x > power_thres (strict); equality counts as below.
REQ-019 Each antenna SHALL run an independent FSM with states IDLE, ARMED, TRIGGERED and HOLD, evaluated once per strobed sample.
REQ-020 IDLE: on above, go to ARMED with cnt=1, or directly to TRIGGERED if min_above <= 1.
REQ-021 ARMED: on above, cnt+1, and go to TRIGGERED when cnt reaches min_above; on below, go to IDLE with cnt=0.
REQ-022 TRIGGERED: on below, go to HOLD with cnt=1, or directly to IDLE if min_below <= 1.
REQ-023 HOLD: on below, cnt+1, and go to IDLE when cnt reaches min_below; on above, go to TRIGGERED with cnt=0.
REQ-024 power_trigger_x SHALL be 1 only in TRIGGERED or HOLD.
REQ-025 Counters SHALL saturate at 255.
REQ-026 The first power_skip strobed samples SHALL neither enter the buffers nor advance the FSMs; the skip counter does not restart until reset.
REQ-027 Changes to power_thres, min_above or min_below SHALL take effect at the next evaluation without disturbing the current state.
REQ-028 stronger_ant SHALL be registered and update in the same cycle as avg_mag_x.

Reset
REQ-029 While reset is low, all outputs SHALL be 0, FSMs SHALL be in IDLE, buffers, sums and counters SHALL be cleared, and the skip counter SHALL be 0; this applies immediately and asynchronously, including mid-packet.
REQ-030 In-flight pipeline samples SHALL be discarded on reset; the first strobe after release is treated as sample 1.

Structure
REQ-031 FSM state encodings and the magnitude width constant SHALL live in the shared common_params definitions.
REQ-032 One sub-module, power_trigger_chan (magnitude, ring buffer, sum, FSM), SHALL be instantiated twice; the top level holds the skip counter and the stronger_ant compare.

Verification
(All scenarios: W=16, thres=1000, min_above=4, min_below=8, skip=0.)
REQ-033 Ant1 constant I=2000, Q=0 -> avg steps by 125 per sample; sample 8 (avg=1000) is not above; power_trigger_1 rises 3 clocks after strobe 12 and stays 0 if min_above=5 and input stops at sample 12.
REQ-034 After 16 samples of 2000, feed zeros -> avg=1000 at zero 8; power_trigger_1 falls 3 clocks after zero 15.
REQ-035 Ant2 I=Q=-32768 on every strobe -> avg_mag_2 reaches 65536 with no overflow; power_trigger_2=1, stronger_ant=1, and ant1 stays 0.
REQ-036 power_skip=5, enable toggled low for 3 cycles between strobes -> the first 5 samples are ignored, held strobes are ignored, and trigger timing shifts accordingly.
REQ-037 Assert reset in TRIGGERED -> all outputs are 0 within the same cycle; after release, a repeat of REQ-033 reproduces identical timing.

Source files
------------

// File: rtl/common_params.sv
// Shared constants, FSM encoding and arithmetic helpers for the dual-antenna
// power trigger.
package common_params;

    localparam int MAG_W  = 17;
    localparam int CNT_W  = 8;
    localparam int SKIP_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ARMED     = 2'd1,
        ST_TRIGGERED = 2'd2,
        ST_HOLD      = 2'd3
    } trig_state_e;

    // One guard bit above the component width keeps |most negative| exact.
    function automatic logic [MAG_W-1:0] abs_mag(input logic signed [MAG_W-1:0] v);
        logic [MAG_W-1:0] neg_v;
        neg_v = -v;
        if (v[MAG_W-1]) begin
            abs_mag = neg_v;
        end else begin
            abs_mag = v;
        end
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if (c == 8'hFF) begin
            sat_inc = c;
        end else begin
            sat_inc = c + 8'd1;
        end
    endfunction

endpackage

// File: rtl/power_trigger_chan.sv
// One antenna: |I|+|Q| magnitude, windowed moving average and the
// IDLE/ARMED/TRIGGERED/HOLD hysteresis FSM.
module power_trigger_chan
    import common_params::*;
#(
    parameter int IQ_DATA_WIDTH = 16,
    parameter int WINDOW_LOG2   = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       sample_valid,
    input  logic [2*IQ_DATA_WIDTH-1:0] data_in,
    input  logic [MAG_W-1:0]           power_thres,
    input  logic [CNT_W-1:0]           min_above,
    input  logic [CNT_W-1:0]           min_below,
    output logic                       power_trigger,
    output logic [MAG_W-1:0]           avg_mag,
    output logic [MAG_W-1:0]           avg_mag_nxt
);

    localparam int SUM_W = MAG_W + WINDOW_LOG2;
    localparam int DEPTH = 1 << WINDOW_LOG2;

    logic signed [IQ_DATA_WIDTH-1:0] i_s;
    logic signed [IQ_DATA_WIDTH-1:0] q_s;
    logic [MAG_W-1:0]                mag_s;
    logic [MAG_W-1:0]                mag_r;
    logic                            mag_vld_r;
    logic [MAG_W-1:0]                ring_r [DEPTH];
    logic [WINDOW_LOG2-1:0]          wr_ptr_r;
    logic [SUM_W-1:0]                sum_r;
    logic [SUM_W-1:0]                sum_nxt_s;
    logic                            sum_vld_r;
    trig_state_e                     state_r;
    trig_state_e                     state_nxt_s;
    logic [CNT_W-1:0]                cnt_r;
    logic [CNT_W-1:0]                cnt_nxt_s;
    logic [CNT_W-1:0]                cnt_inc_s;
    logic [CNT_W-1:0]                min_above_s;
    logic [CNT_W-1:0]                min_below_s;
    logic                            eval_s;
    logic                            above_s;
    logic                            trig_r;

    assign i_s   = data_in[2*IQ_DATA_WIDTH-1:IQ_DATA_WIDTH];
    assign q_s   = data_in[IQ_DATA_WIDTH-1:0];
    assign mag_s = abs_mag(MAG_W'(i_s)) + abs_mag(MAG_W'(q_s));

    // Stage 1: register the magnitude of the accepted sample.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mag_r     <= '0;
            mag_vld_r <= 1'b0;
        end else if (enable) begin
            mag_vld_r <= sample_valid;
            if (sample_valid) begin
                mag_r <= mag_s;
            end
        end
    end

    // Running sum: add the newest magnitude, drop the entry it overwrites.
    always_comb begin
        sum_nxt_s = sum_r;
        if (enable && mag_vld_r) begin
            sum_nxt_s = sum_r + SUM_W'(mag_r) - SUM_W'(ring_r[wr_ptr_r]);
        end else begin
            sum_nxt_s = sum_r;
        end
    end

    // Stage 2: ring buffer write and pointer advance.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                ring_r[i] <= '0;
            end
            wr_ptr_r <= '0;
        end else if (enable && mag_vld_r) begin
            ring_r[wr_ptr_r] <= mag_r;
            wr_ptr_r         <= wr_ptr_r + 1'b1;
        end
    end

    // Stage 2: running sum register and its valid flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sum_r     <= '0;
            sum_vld_r <= 1'b0;
        end else if (enable) begin
            sum_r     <= sum_nxt_s;
            sum_vld_r <= mag_vld_r;
        end
    end

    assign avg_mag     = sum_r[SUM_W-1:WINDOW_LOG2];
    assign avg_mag_nxt = sum_nxt_s[SUM_W-1:WINDOW_LOG2];

    assign eval_s      = enable & sum_vld_r;
    assign above_s     = (avg_mag > power_thres);
    assign min_above_s = (min_above == 8'd0) ? 8'd1 : min_above;
    assign min_below_s = (min_below == 8'd0) ? 8'd1 : min_below;
    assign cnt_inc_s   = sat_inc(cnt_r);

    // Hysteresis FSM: one step per evaluated sample, thresholds read live.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        if (eval_s) begin
            case (state_r)
                ST_IDLE: begin
                    if (above_s) begin
                        if (min_above_s <= 8'd1) begin
                            state_nxt_s = ST_TRIGGERED;
                            cnt_nxt_s   = 8'd0;
                        end else begin
                            state_nxt_s = ST_ARMED;
                            cnt_nxt_s   = 8'd1;
                        end
                    end else begin
                        cnt_nxt_s = 8'd0;
                    end
                end
                ST_ARMED: begin
                    if (above_s) begin
                        if (cnt_inc_s >= min_above_s) begin
                            state_nxt_s = ST_TRIGGERED;
                            cnt_nxt_s   = 8'd0;
                        end else begin
                            cnt_nxt_s = cnt_inc_s;
                        end
                    end else begin
                        state_nxt_s = ST_IDLE;
                        cnt_nxt_s   = 8'd0;
                    end
                end
                ST_TRIGGERED: begin
                    if (above_s) begin
                        cnt_nxt_s = 8'd0;
                    end else if (min_below_s <= 8'd1) begin
                        state_nxt_s = ST_IDLE;
                        cnt_nxt_s   = 8'd0;
                    end else begin
                        state_nxt_s = ST_HOLD;
                        cnt_nxt_s   = 8'd1;
                    end
                end
                ST_HOLD: begin
                    if (above_s) begin
                        state_nxt_s = ST_TRIGGERED;
                        cnt_nxt_s   = 8'd0;
                    end else if (cnt_inc_s >= min_below_s) begin
                        state_nxt_s = ST_IDLE;
                        cnt_nxt_s   = 8'd0;
                    end else begin
                        cnt_nxt_s = cnt_inc_s;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = 8'd0;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
            cnt_nxt_s   = cnt_r;
        end
    end

    // Stage 3: FSM state, counter and registered trigger.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= 8'd0;
            trig_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            trig_r  <= (state_nxt_s == ST_TRIGGERED) || (state_nxt_s == ST_HOLD);
        end
    end

    assign power_trigger = trig_r;

endmodule

// File: rtl/dual_power_trigger.sv
// Two-antenna power trigger: shared start-up skip counter, two identical
// channels and a registered stronger-antenna flag.
module dual_power_trigger
    import common_params::*;
#(
    parameter int IQ_DATA_WIDTH = 16,
    parameter int WINDOW_LOG2   = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [2*IQ_DATA_WIDTH-1:0] data_ant1_in,
    input  logic [2*IQ_DATA_WIDTH-1:0] data_ant2_in,
    input  logic                       data_in_strobe,
    input  logic [MAG_W-1:0]           power_thres,
    input  logic [CNT_W-1:0]           min_above,
    input  logic [CNT_W-1:0]           min_below,
    input  logic [SKIP_W-1:0]          power_skip,
    output logic                       power_trigger_1,
    output logic                       power_trigger_2,
    output logic [MAG_W-1:0]           avg_mag_1,
    output logic [MAG_W-1:0]           avg_mag_2,
    output logic                       stronger_ant
);

    logic [SKIP_W-1:0] skip_cnt_r;
    logic              strobe_s;
    logic              skip_done_s;
    logic              accept_s;
    logic [MAG_W-1:0]  avg_nxt_1_s;
    logic [MAG_W-1:0]  avg_nxt_2_s;
    logic              stronger_r;

    assign strobe_s    = enable & data_in_strobe;
    assign skip_done_s = (skip_cnt_r >= power_skip);
    assign accept_s    = strobe_s & skip_done_s;

    // Counts discarded start-up samples; stops once the skip quota is met.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            skip_cnt_r <= 16'd0;
        end else if (strobe_s && !skip_done_s) begin
            skip_cnt_r <= skip_cnt_r + 16'd1;
        end
    end

    power_trigger_chan #(
        .IQ_DATA_WIDTH (IQ_DATA_WIDTH),
        .WINDOW_LOG2   (WINDOW_LOG2)
    ) u_chan_1 (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .sample_valid  (accept_s),
        .data_in       (data_ant1_in),
        .power_thres   (power_thres),
        .min_above     (min_above),
        .min_below     (min_below),
        .power_trigger (power_trigger_1),
        .avg_mag       (avg_mag_1),
        .avg_mag_nxt   (avg_nxt_1_s)
    );

    power_trigger_chan #(
        .IQ_DATA_WIDTH (IQ_DATA_WIDTH),
        .WINDOW_LOG2   (WINDOW_LOG2)
    ) u_chan_2 (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .sample_valid  (accept_s),
        .data_in       (data_ant2_in),
        .power_thres   (power_thres),
        .min_above     (min_above),
        .min_below     (min_below),
        .power_trigger (power_trigger_2),
        .avg_mag       (avg_mag_2),
        .avg_mag_nxt   (avg_nxt_2_s)
    );

    // Compare the averages about to be registered so the flag lands with them.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stronger_r <= 1'b0;
        end else begin
            stronger_r <= (avg_nxt_2_s > avg_nxt_1_s);
        end
    end

    assign stronger_ant = stronger_r;

endmodule

// File: tb/tb_dual_power_trigger.sv
// Directed bench for dual_power_trigger: W=16, thres=1000, min_above=4,
// min_below=8 unless a step changes them.
module tb_dual_power_trigger;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b1;
    logic [31:0] data_ant1_in = 32'd0;
    logic [31:0] data_ant2_in = 32'd0;
    logic        data_in_strobe = 1'b0;
    logic [16:0] power_thres = 17'd1000;
    logic [7:0]  min_above = 8'd4;
    logic [7:0]  min_below = 8'd8;
    logic [15:0] power_skip = 16'd0;
    logic        power_trigger_1;
    logic        power_trigger_2;
    logic [16:0] avg_mag_1;
    logic [16:0] avg_mag_2;
    logic        stronger_ant;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] A2000 = 32'h07D0_0000;
    localparam logic [31:0] AMIN  = 32'h8000_8000;
    localparam logic [31:0] JUNK  = 32'h7FFF_0000;

    dual_power_trigger dut (
        .clock           (clock),
        .reset           (reset),
        .enable          (enable),
        .data_ant1_in    (data_ant1_in),
        .data_ant2_in    (data_ant2_in),
        .data_in_strobe  (data_in_strobe),
        .power_thres     (power_thres),
        .min_above       (min_above),
        .min_below       (min_below),
        .power_skip      (power_skip),
        .power_trigger_1 (power_trigger_1),
        .power_trigger_2 (power_trigger_2),
        .avg_mag_1       (avg_mag_1),
        .avg_mag_2       (avg_mag_2),
        .stronger_ant    (stronger_ant)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Ant1 ramp: 2000 for samples 1..16, then zeros.
    function automatic int exp_avg(input int s);
        if (s <= 16) return 125 * s;
        else if (s >= 32) return 0;
        else return 125 * (32 - s);
    endfunction

    function automatic logic exp_trig(input int s);
        return (s >= 12) && (s <= 30);
    endfunction

    task automatic do_reset();
        @(negedge clock);
        #2 reset = 1'b0;
        data_in_strobe = 1'b0;
        #1;
        chk("rst_trig1", power_trigger_1, 0);
        chk("rst_trig2", power_trigger_2, 0);
        chk("rst_avg1", avg_mag_1, 0);
        chk("rst_avg2", avg_mag_2, 0);
        chk("rst_stronger", stronger_ant, 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    // Back-to-back strobes; avg of sample j-2 and trigger of sample j-3 are
    // visible at the falling edge where sample j is driven.
    task automatic run_ramp(input int n);
        for (int j = 1; j <= n + 3; j++) begin
            @(negedge clock);
            if (j - 2 >= 1 && j - 2 <= n) chk("ramp_avg1", avg_mag_1, exp_avg(j - 2));
            if (j - 3 >= 1 && j - 3 <= n) chk("ramp_trig1", power_trigger_1, exp_trig(j - 3));
            if (j <= n) begin
                data_in_strobe = 1'b1;
                data_ant1_in   = (j <= 16) ? A2000 : 32'd0;
                data_ant2_in   = 32'd0;
            end else begin
                data_in_strobe = 1'b0;
            end
        end
    endtask

    task automatic send_settle(input logic [31:0] a1);
        @(negedge clock);
        data_in_strobe = 1'b1;
        data_ant1_in   = a1;
        @(negedge clock);
        data_in_strobe = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    initial begin
        // Power-on reset and the basic ramp up and decay on ant1.
        do_reset();
        run_ramp(36);
        chk("ramp_trig2", power_trigger_2, 0);
        chk("ramp_stronger", stronger_ant, 0);

        // min_above=5 with input ending at sample 12 never triggers.
        do_reset();
        min_above = 8'd5;
        for (int j = 1; j <= 12; j++) begin
            @(negedge clock);
            data_in_strobe = 1'b1;
            data_ant1_in   = A2000;
        end
        @(negedge clock);
        data_in_strobe = 1'b0;
        repeat (5) @(negedge clock);
        chk("min5_avg1", avg_mag_1, 1500);
        chk("min5_trig1", power_trigger_1, 0);
        min_above = 8'd4;

        // Ant2 full-scale negative components: average saturates at 65536.
        do_reset();
        for (int j = 1; j <= 22; j++) begin
            @(negedge clock);
            if (j - 2 >= 1) begin
                chk("amin_avg2", avg_mag_2, 4096 * ((j - 2) < 16 ? (j - 2) : 16));
                chk("amin_stronger", stronger_ant, 1);
            end
            data_in_strobe = (j <= 20);
            data_ant1_in   = 32'd0;
            data_ant2_in   = AMIN;
        end
        repeat (3) @(negedge clock);
        chk("amin_avg2_final", avg_mag_2, 65536);
        chk("amin_trig2", power_trigger_2, 1);
        chk("amin_trig1", power_trigger_1, 0);
        chk("amin_avg1", avg_mag_1, 0);
        data_ant2_in = 32'd0;

        // Skip 5 samples; strobes while disabled count for nothing.
        do_reset();
        power_skip = 16'd5;
        repeat (3) send_settle(JUNK);
        @(negedge clock);
        enable = 1'b0;
        data_in_strobe = 1'b1;
        data_ant1_in = JUNK;
        repeat (3) @(negedge clock);
        data_in_strobe = 1'b0;
        enable = 1'b1;
        repeat (2) send_settle(JUNK);
        chk("skip_avg1", avg_mag_1, 0);
        send_settle(A2000);
        chk("skip_first_avg1", avg_mag_1, 125);
        for (int k = 2; k <= 11; k++) send_settle(A2000);
        chk("skip_11_avg1", avg_mag_1, 1375);
        chk("skip_11_trig1", power_trigger_1, 0);
        @(negedge clock);
        data_in_strobe = 1'b1;
        data_ant1_in = A2000;
        @(negedge clock);
        data_in_strobe = 1'b0;
        enable = 1'b0;
        repeat (3) @(negedge clock);
        chk("freeze_avg1", avg_mag_1, 1375);
        chk("freeze_trig1", power_trigger_1, 0);
        enable = 1'b1;
        repeat (3) @(negedge clock);
        chk("thaw_avg1", avg_mag_1, 1500);
        chk("thaw_trig1", power_trigger_1, 1);

        // Reset while triggered, then the ramp timing must repeat exactly.
        do_reset();
        power_skip = 16'd0;
        run_ramp(14);

        // min of 0 acts as 1; a threshold change alone does not move the FSM.
        do_reset();
        power_thres = 17'd100;
        min_above = 8'd0;
        min_below = 8'd0;
        send_settle(A2000);
        chk("min0_trig_on", power_trigger_1, 1);
        power_thres = 17'd200;
        repeat (3) @(negedge clock);
        chk("thres_hold_trig", power_trigger_1, 1);
        send_settle(32'd0);
        chk("min0_trig_off", power_trigger_1, 0);
        chk("min0_avg1", avg_mag_1, 125);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
